// File: rtl/dm_responder.sv
// Data-memory responder: word RAM with byte/half/word lane merging, load extension,
// post-reset clear sweep and illegal-access error flag. Optional store trace: DM_TRACE_EN.
module dm_responder #(
  parameter int unsigned WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        lsign,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        err,
  output logic [31:0] err_addr
);

  localparam int unsigned AW = $clog2(WORDS);

  typedef enum logic {CLEAR, READY} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            err_q, err_d;
  logic [31:0]     err_addr_q, err_addr_d;

  logic [31:0]     mem [WORDS];

  logic [AW-1:0]   idx;
  logic [31:0]     word_rd;
  logic            is_half, is_byte;
  logic            aligned, in_range, legal, ready;
  logic            store_en, load_en, wr_en;
  logic [AW-1:0]   wr_idx;
  logic [31:0]     wr_data, merged;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic            unused_pc;

  assign idx      = addr[AW+1:2];
  assign word_rd  = mem[idx];
  assign is_half  = (size == 2'b01);
  assign is_byte  = (size == 2'b10);
  assign aligned  = is_byte | (is_half & ~addr[0]) | (~is_half & ~is_byte & (addr[1:0] == 2'b00));
  assign in_range = ((addr >> (AW + 2)) == 32'd0);
  assign legal    = aligned & in_range;
  assign ready    = (state_q == READY);
  assign store_en = ready & we & legal & ~reset;
  assign load_en  = ready & re & legal;
  assign unused_pc = ^pc;

  // Replace only the addressed lanes of the current word
  always_comb begin
    merged = word_rd;
    case (size)
      2'b01: begin
        if (addr[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      2'b10:   merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
      default: merged = wdata;
    endcase
  end

  // Combinational load path with extension
  always_comb begin
    lane_b = word_rd[{addr[1:0], 3'b000} +: 8];
    lane_h = addr[1] ? word_rd[31:16] : word_rd[15:0];
    rdata  = 32'd0;
    if (load_en) begin
      case (size)
        2'b01:   rdata = {{16{lsign & lane_h[15]}}, lane_h};
        2'b10:   rdata = {{24{lsign & lane_b[7]}}, lane_b};
        default: rdata = word_rd;
      endcase
    end
  end

  // Single write port shared by the clear sweep and committed stores
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = idx;
    wr_data = merged;
    if ((state_q == CLEAR) && !reset) begin
      wr_en   = 1'b1;
      wr_idx  = ptr_q;
      wr_data = 32'd0;
    end else if (store_en) begin
      wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
`ifdef DM_TRACE_EN
    if (store_en) $display("@%08h: *%08h <= %08h", pc, {addr[31:2], 2'b00}, merged);
`endif
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    err_d      = ready & (re | we) & ~legal;
    err_addr_d = err_d ? addr : err_addr_q;
    if (state_q == CLEAR) begin
      ptr_d = ptr_q + AW'(1);
      if (ptr_q == AW'(WORDS - 1)) begin
        state_d = READY;
        ptr_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLEAR;
      ptr_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign busy     = (state_q == CLEAR);
  assign err      = err_q;
  assign err_addr = err_addr_q;

endmodule
